wb_clint: RTL and testbench

//  Wishbone B4 responder implementing a core-local interruptor (mtime, mtimecmp, msip).

---
 rtl/wb_clint.sv | 112 +++++++++++
 tb/tb_wb_clint.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_clint.sv
// Wishbone B4 core-local interruptor: 64-bit mtime/mtimecmp timer and msip software
// interrupt in a 32-byte window, one-cycle registered ack/err per access.
module wb_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [4:0] OFF_MSIP   = 5'h00;
    localparam logic [4:0] OFF_CMP_LO = 5'h08;
    localparam logic [4:0] OFF_CMP_HI = 5'h0C;
    localparam logic [4:0] OFF_TIM_LO = 5'h10;
    localparam logic [4:0] OFF_TIM_HI = 5'h14;

    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip_next;
    logic [31:0] prescaler, prescaler_next;
    logic        tick;
    logic        req, known, mapped, wr;
    logic [4:0]  offset;
    logic [31:0] rdata;

    // Every access is treated as a classic cycle, so the burst hints are dropped.
    logic unused_burst;
    assign unused_burst = &{1'b0, wbs_cti_i, wbs_bte_i};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
        offset = wbs_addr_i[4:0];
        known  = 1'b0;
        rdata  = 32'h0;
        case (offset)
            OFF_MSIP:   begin known = 1'b1; rdata = {31'h0, software_interrupt}; end
            OFF_CMP_LO: begin known = 1'b1; rdata = mtimecmp[31:0];              end
            OFF_CMP_HI: begin known = 1'b1; rdata = mtimecmp[63:32];             end
            OFF_TIM_LO: begin known = 1'b1; rdata = mtime[31:0];                 end
            OFF_TIM_HI: begin known = 1'b1; rdata = mtime[63:32];                end
            default:    ;
        endcase
        mapped = known & (wbs_addr_i[31:5] == BASE_ADDR[31:5]);
        wr     = req & mapped & wbs_we_i;
    end

    always_comb begin
        tick           = (prescaler == 32'(TICK_DIV - 1));
        prescaler_next = tick ? 32'h0 : prescaler + 32'h1;
        mtime_next     = tick ? mtime + 64'h1 : mtime;
        mtimecmp_next  = mtimecmp;
        msip_next      = software_interrupt;
        // Bus lanes override the incremented value lane by lane; no carry from a
        // freshly written low half into the high half.
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs_sel_i[i]) begin
                    case (offset)
                        OFF_CMP_LO: mtimecmp_next[8*i +: 8]      = wbs_dat_i[8*i +: 8];
                        OFF_CMP_HI: mtimecmp_next[32 + 8*i +: 8] = wbs_dat_i[8*i +: 8];
                        OFF_TIM_LO: mtime_next[8*i +: 8]         = wbs_dat_i[8*i +: 8];
                        OFF_TIM_HI: mtime_next[32 + 8*i +: 8]    = wbs_dat_i[8*i +: 8];
                        default:    ;
                    endcase
                end
            end
            if (offset == OFF_MSIP && wbs_sel_i[0]) begin
                msip_next = wbs_dat_i[0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime              <= 64'h0;
            mtimecmp           <= '1;
            prescaler          <= 32'h0;
            software_interrupt <= 1'b0;
            timer_interrupt    <= 1'b0;
            wbs_ack_o          <= 1'b0;
            wbs_err_o          <= 1'b0;
            wbs_dat_o          <= 32'h0;
        end else begin
            mtime              <= mtime_next;
            mtimecmp           <= mtimecmp_next;
            prescaler          <= prescaler_next;
            software_interrupt <= msip_next;
            timer_interrupt    <= (mtime_next >= mtimecmp_next);
            wbs_ack_o          <= req & mapped;
            wbs_err_o          <= req & ~mapped;
            wbs_dat_o          <= (req & mapped & ~wbs_we_i) ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_clint.sv
// Self-checking bench for wb_clint: directed scenarios plus random bus traffic, all
// outputs compared every cycle against a register-level behavioural model.
module tb_wb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          TDIV = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbs_addr_i = '0, wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = '0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [2:0]  wbs_cti_i = '0;
    logic [1:0]  wbs_bte_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, timer_interrupt, software_interrupt;

    int checks = 0;
    int errors = 0;

    wb_clint #(.BASE_ADDR(BASE), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_addr_i(wbs_addr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .timer_interrupt(timer_interrupt), .software_interrupt(software_interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: registers as plain integers ----------------
    logic [63:0] m_time = 64'h0, m_cmp = '1;
    logic        m_msip = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_ti = 1'b0;
    logic [31:0] m_dat = 32'h0;
    int          m_presc = 0;

    function automatic bit is_mapped(input logic [31:0] a);
        return (a[31:5] == BASE[31:5]) &&
               (a[4:0] == 5'h00 || a[4:0] == 5'h08 || a[4:0] == 5'h0C ||
                a[4:0] == 5'h10 || a[4:0] == 5'h14);
    endfunction

    function automatic logic [31:0] reg_word(input logic [4:0] off);
        case (off)
            5'h00:   return {31'h0, m_msip};
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return m_time[31:0];
            5'h14:   return m_time[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_time = 64'h0; m_cmp = '1; m_msip = 1'b0; m_presc = 0;
            m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0; m_ti = 1'b0;
        end else begin
            bit req, hit;
            logic [63:0] nt;
            req   = wbs_cyc_i && wbs_stb_i && !m_ack && !m_err;
            hit   = req && is_mapped(wbs_addr_i);
            m_dat = (hit && !wbs_we_i) ? reg_word(wbs_addr_i[4:0]) : 32'h0;
            m_ack = hit;
            m_err = req && !hit;
            nt = m_time;
            if (m_presc == TDIV - 1) begin
                m_presc = 0;
                nt = nt + 64'd1;
            end else begin
                m_presc = m_presc + 1;
            end
            if (hit && wbs_we_i) begin
                case (wbs_addr_i[4:0])
                    5'h00: if (wbs_sel_i[0]) m_msip = wbs_dat_i[0];
                    5'h08: m_cmp[31:0]  = merge(m_cmp[31:0], wbs_dat_i, wbs_sel_i);
                    5'h0C: m_cmp[63:32] = merge(m_cmp[63:32], wbs_dat_i, wbs_sel_i);
                    5'h10: nt[31:0]     = merge(nt[31:0], wbs_dat_i, wbs_sel_i);
                    5'h14: nt[63:32]    = merge(nt[63:32], wbs_dat_i, wbs_sel_i);
                    default: ;
                endcase
            end
            m_time = nt;
            m_ti   = (m_time >= m_cmp);
        end
    end

    // Single compare process: all outputs, every cycle, away from the active edge.
    always @(negedge clk) begin
        check("ack", {63'h0, wbs_ack_o}, {63'h0, m_ack});
        check("err", {63'h0, wbs_err_o}, {63'h0, m_err});
        check("dat", {32'h0, wbs_dat_o}, {32'h0, m_dat});
        check("timer_irq", {63'h0, timer_interrupt}, {63'h0, m_ti});
        check("sw_irq", {63'h0, software_interrupt}, {63'h0, m_msip});
    end

    // ---------------- bus driver ----------------
    task automatic wb(input logic [31:0] addr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output logic got_err);
        bit done = 0;
        @(negedge clk);
        wbs_addr_i = addr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        rdata = 32'h0; got_err = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (wbs_ack_o || wbs_err_o) begin
                done = 1; rdata = wbs_dat_o; got_err = wbs_err_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL wb_timeout addr=%h", addr);
        end
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d; logic e;
        wb(BASE | 32'(off), 1'b1, dat, sel, d, e);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] d);
        logic e;
        wb(BASE | 32'(off), 1'b0, 32'h0, 4'hF, d, e);
    endtask

    logic [31:0] d;
    logic        e;
    int          acks;
    bit          seen;
    logic [31:0] bad_addr [4];

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        check("rst_ack", {63'h0, wbs_ack_o}, 64'h0);
        check("rst_ti", {63'h0, timer_interrupt}, 64'h0);
        check("rst_dat", {32'h0, wbs_dat_o}, 64'h0);
        rst_n = 1'b1;
        rd(5'h10, d); check("mtime_after_rst_a", {32'h0, d}, 64'd1);
        rd(5'h10, d); check("mtime_after_rst_b", {32'h0, d}, 64'd3);
        rd(5'h08, d); check("cmp_lo_rst", {32'h0, d}, 64'hFFFF_FFFF);
        rd(5'h0C, d); check("cmp_hi_rst", {32'h0, d}, 64'hFFFF_FFFF);
        rd(5'h00, d); check("msip_rst", {32'h0, d}, 64'h0);

        // 2: timer compare
        wr(5'h10, 32'h0, 4'hF); wr(5'h14, 32'h0, 4'hF);
        wr(5'h0C, 32'h0, 4'hF); wr(5'h08, 32'd20, 4'hF);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = timer_interrupt;
        end
        check("timer_rises", {63'h0, seen}, 64'h1);
        rd(5'h08, d); check("cmp_lo_20", {32'h0, d}, 64'd20);
        wr(5'h08, 32'd1000, 4'hF);
        check("timer_falls", {63'h0, timer_interrupt}, 64'h0);

        // 3: carry and wrap
        wr(5'h14, 32'h0, 4'hF); wr(5'h10, 32'hFFFF_FFFE, 4'hF);
        rd(5'h10, d); check("carry_lo", {32'h0, d}, 64'hFFFF_FFFF);
        rd(5'h14, d); check("carry_hi", {32'h0, d}, 64'h1);
        wr(5'h08, 32'hFFFF_FFFF, 4'hF); wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
        wr(5'h14, 32'hFFFF_FFFF, 4'hF); wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        check("wrap_ti_max", {63'h0, timer_interrupt}, 64'h1);
        @(negedge clk);
        check("wrap_ti_zero", {63'h0, timer_interrupt}, 64'h0);

        // 4: software interrupt lanes
        wr(5'h00, 32'hFFFF_FFFF, 4'b0001);
        check("sw_set", {63'h0, software_interrupt}, 64'h1);
        rd(5'h00, d); check("msip_read", {32'h0, d}, 64'h1);
        wr(5'h00, 32'h0, 4'b1110);
        check("sw_hold", {63'h0, software_interrupt}, 64'h1);
        wr(5'h00, 32'h0, 4'b0001);
        check("sw_clear", {63'h0, software_interrupt}, 64'h0);

        // 5: held strobe and unmapped accesses
        @(negedge clk);
        wbs_addr_i = BASE; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("held_stb_acks", 64'(acks), 64'd3);
        bad_addr[0] = BASE + 32'h04; bad_addr[1] = BASE + 32'h18;
        bad_addr[2] = BASE + 32'h20; bad_addr[3] = BASE + 32'h09;
        foreach (bad_addr[i]) begin
            wb(bad_addr[i], 1'b1, 32'hDEAD_BEEF, 4'hF, d, e);
            check("unmapped_err", {63'h0, e}, 64'h1);
        end
        @(negedge clk);
        wbs_cyc_i = 1'b1;                       // cyc without stb: no response
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b0;

        // 6: byte lanes, then reset during an ack
        wr(5'h08, 32'hFFFF_FFFF, 4'hF);
        wr(5'h08, 32'h1122_3344, 4'b0101);
        rd(5'h08, d); check("lane_merge", {32'h0, d}, 64'hFF22_FF44);
        wr(5'h00, 32'h1, 4'h1);
        @(negedge clk);
        wbs_addr_i = BASE | 32'h08; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_ack", {63'h0, wbs_ack_o}, 64'h0);
        check("mid_rst_sw", {63'h0, software_interrupt}, 64'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rd(5'h08, d); check("cmp_after_mid_rst", {32'h0, d}, 64'hFFFF_FFFF);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  off;
            logic [31:0] a;
            off = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) off = {off[4:2], 2'b00};
            a = ($urandom_range(0, 15) == 0) ? (BASE + 32'h20 + 32'(off)) : (BASE | 32'(off));
            wb(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), d, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
